// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/add/compare, bit-serial shifts, optional
// shift-add multiply (enabled by defining ALU_ITER_MUL_EN).
module alu_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       Flags,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int unsigned SH = $clog2(WIDTH);
  localparam int unsigned CW = SH + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SHL  = 4'd1;
  localparam logic [3:0] OP_SHR  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_CMP  = 4'd7;
`ifdef ALU_ITER_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd8;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef ALU_ITER_MUL_EN
    MUL   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_result;
  logic [4:0]           r_flags;
  logic [WIDTH-1:0]     r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_dir;

  logic                 w_rdy;
  logic                 w_accept;
  logic                 w_is_shift;
  logic                 w_is_mul;
  logic                 w_load_fast;
  logic                 w_load_shift;
  logic                 w_load_mul;
  logic [SH-1:0]        w_amt;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_fast_res;
  logic                 w_fast_c;
  logic                 w_fast_v;
  logic                 w_fast_err;
  logic [4:0]           w_fast_flags;

  logic [WIDTH-1:0]     w_sh_next;
  logic                 w_sh_out;

`ifdef ALU_ITER_MUL_EN
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH:0]       w_madd;
  logic [2*WIDTH-1:0]   w_prod_nxt;
`endif

  assign w_amt      = B[SH-1:0];
  assign w_is_shift = ((Op == OP_SHL) || (Op == OP_SHR)) && (w_amt != '0);
`ifdef ALU_ITER_MUL_EN
  assign w_is_mul   = (Op == OP_MUL);
`else
  assign w_is_mul   = 1'b0;
`endif

  assign InReady  = w_rdy;
  assign OutValid = (r_state == DONE);
  assign Result   = r_result;
  assign Flags    = r_flags;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Readiness is gated by Rst_n so it reads 0 while reset is held,
  // then 1 immediately after release since the state is IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_rdy        = 1'b0;
    unique case (r_state)
      IDLE:  w_rdy = 1'b1;
      SHIFT: if (r_cnt == CNT_ONE) w_state_nxt = DONE;
`ifdef ALU_ITER_MUL_EN
      MUL:   if (r_cnt == CNT_ONE) w_state_nxt = DONE;
`endif
      DONE: begin
        w_rdy = OutReady;
        if (OutReady) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_rdy        = w_rdy & Rst_n;
    w_accept     = InValid & w_rdy;
    w_load_shift = w_accept & w_is_shift;
    w_load_mul   = w_accept & w_is_mul;
    w_load_fast  = w_accept & ~w_is_shift & ~w_is_mul;
    if (w_load_shift) begin
      w_state_nxt = SHIFT;
`ifdef ALU_ITER_MUL_EN
    end else if (w_load_mul) begin
      w_state_nxt = MUL;
`endif
    end else if (w_load_fast) begin
      w_state_nxt = DONE;
    end
  end

  assign w_sum = {1'b0, A} + {1'b0, B};

  always_comb begin
    w_fast_res = '0;
    w_fast_c   = 1'b0;
    w_fast_v   = 1'b0;
    w_fast_err = 1'b0;
    case (Op)
      OP_ADD: begin
        w_fast_res = w_sum[WIDTH-1:0];
        w_fast_c   = w_sum[WIDTH];
        w_fast_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SHL, OP_SHR: w_fast_res = A;
      OP_AND:  w_fast_res = A & B;
      OP_OR:   w_fast_res = A | B;
      OP_XOR:  w_fast_res = A ^ B;
      OP_NAND: w_fast_res = ~(A & B);
      OP_CMP:  w_fast_res = (A >= B) ? '1 : '0;
      default: w_fast_err = 1'b1;
    endcase
    if (w_fast_err) w_fast_flags = 5'b10000;
    else            w_fast_flags = {1'b0, w_fast_v, w_fast_res[WIDTH-1], w_fast_c, ~|w_fast_res};
  end

  assign w_sh_next = r_dir ? {1'b0, r_acc[WIDTH-1:1]} : {r_acc[WIDTH-2:0], 1'b0};
  assign w_sh_out  = r_dir ? r_acc[0] : r_acc[WIDTH-1];

`ifdef ALU_ITER_MUL_EN
  // Upper half accumulates A when the current multiplier bit (held in the
  // low half) is set; the whole product then shifts right one place.
  assign w_madd     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_madd, r_prod[WIDTH-1:1]};
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
`ifdef ALU_ITER_MUL_EN
      r_prod   <= '0;
      r_mcand  <= '0;
`endif
    end else begin
      if (w_load_fast) begin
        r_result <= w_fast_res;
        r_flags  <= w_fast_flags;
      end
      if (w_load_shift) begin
        r_acc <= A;
        r_cnt <= CW'(w_amt);
        r_dir <= (Op == OP_SHR);
      end
      if (r_state == SHIFT) begin
        r_acc <= w_sh_next;
        r_cnt <= r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          r_result <= w_sh_next;
          r_flags  <= {2'b00, w_sh_next[WIDTH-1], w_sh_out, ~|w_sh_next};
        end
      end
`ifdef ALU_ITER_MUL_EN
      if (w_load_mul) begin
        r_prod  <= {{WIDTH{1'b0}}, B};
        r_mcand <= A;
        r_cnt   <= CW'(WIDTH);
      end
      if (r_state == MUL) begin
        r_prod <= w_prod_nxt;
        r_cnt  <= r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          r_result <= w_prod_nxt[WIDTH-1:0];
          r_flags  <= {2'b00, w_prod_nxt[WIDTH-1], |w_prod_nxt[2*WIDTH-1:WIDTH],
                       ~|w_prod_nxt[WIDTH-1:0]};
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (WIDTH=8): vector table plus handshake,
// back-pressure and reset-abort sequences.
module tb_alu_iter;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] A, B;
  logic [3:0] Op;
  logic       InValid, InReady;
  logic [7:0] Result;
  logic [4:0] Flags;
  logic       OutValid, OutReady;

  int n_err = 0;
  int n_chk = 0;

  alu_iter #(.WIDTH(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .A(A), .B(B), .Op(Op),
    .InValid(InValid), .InReady(InReady),
    .Result(Result), .Flags(Flags), .OutValid(OutValid), .OutReady(OutReady)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [4:0] flg;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE, scramble the inputs after accept, then wait
  // (bounded) for OutValid and consume the result.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic [4:0] flg, output int lat);
    @(negedge Clk);
    A = a; B = b; Op = op; InValid = 1'b1; OutReady = 1'b0;
    @(posedge Clk); #1;
    InValid = 1'b0; A = ~a; B = ~b; Op = 4'h5;
    lat = 1;
    while (OutValid !== 1'b1 && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    res = Result;
    flg = Flags;
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] res;
    logic [4:0] flg;
    int lat;

    // {op, a, b, result, {Err,V,N,C,Z}, latency}
    vecs.push_back('{4'd0, 8'h7F, 8'h01, 8'h80, 5'b01100, 1});
    vecs.push_back('{4'd0, 8'hFF, 8'h01, 8'h00, 5'b00011, 1});
    vecs.push_back('{4'd0, 8'h80, 8'h80, 8'h00, 5'b01011, 1});
    vecs.push_back('{4'd1, 8'h81, 8'h01, 8'h02, 5'b00010, 2});
    vecs.push_back('{4'd2, 8'h81, 8'h03, 8'h10, 5'b00000, 4});
    vecs.push_back('{4'd1, 8'h01, 8'h07, 8'h80, 5'b00100, 8});
    vecs.push_back('{4'd1, 8'hFF, 8'h07, 8'h80, 5'b00110, 8});
    vecs.push_back('{4'd2, 8'h5A, 8'h08, 8'h5A, 5'b00000, 1});
    vecs.push_back('{4'd3, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1});
    vecs.push_back('{4'd4, 8'h00, 8'h00, 8'h00, 5'b00001, 1});
    vecs.push_back('{4'd5, 8'hAA, 8'h55, 8'hFF, 5'b00100, 1});
    vecs.push_back('{4'd6, 8'hFF, 8'hFF, 8'h00, 5'b00001, 1});
    vecs.push_back('{4'd6, 8'hF0, 8'h3C, 8'hCF, 5'b00100, 1});
    vecs.push_back('{4'd7, 8'h10, 8'h10, 8'hFF, 5'b00100, 1});
    vecs.push_back('{4'd7, 8'h0F, 8'h10, 8'h00, 5'b00001, 1});
    vecs.push_back('{4'd7, 8'hFF, 8'h00, 8'hFF, 5'b00100, 1});
    vecs.push_back('{4'd9, 8'h05, 8'h03, 8'h00, 5'b10000, 1});
    vecs.push_back('{4'd15, 8'hFF, 8'hFF, 8'h00, 5'b10000, 1});
`ifdef ALU_ITER_MUL_EN
    vecs.push_back('{4'd8, 8'h10, 8'h11, 8'h10, 5'b00010, 9});
    vecs.push_back('{4'd8, 8'hFF, 8'hFF, 8'h01, 5'b00010, 9});
    vecs.push_back('{4'd8, 8'h03, 8'h05, 8'h0F, 5'b00000, 9});
`else
    vecs.push_back('{4'd8, 8'h10, 8'h11, 8'h00, 5'b10000, 1});
    vecs.push_back('{4'd8, 8'h03, 8'h05, 8'h00, 5'b10000, 1});
`endif

    Rst_n = 1'b0; A = '0; B = '0; Op = '0; InValid = 1'b0; OutReady = 1'b0;
    #12;
    chk("rst_outvalid", OutValid, 1'b0);
    chk("rst_result", Result, 8'h00);
    chk("rst_flags", Flags, 5'b00000);
    chk("rst_inready", InReady, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("post_rst_inready", InReady, 1'b1);

    // ADD then CMP back-to-back with no bubble
    @(negedge Clk);
    A = 8'hFF; B = 8'h01; Op = 4'd0; InValid = 1'b1; OutReady = 1'b1;
    @(posedge Clk); #1;
    chk("b2b_add_valid", OutValid, 1'b1);
    chk("b2b_add_res", Result, 8'h00);
    chk("b2b_add_flags", Flags, 5'b00011);
    chk("b2b_add_inready", InReady, 1'b1);
    A = 8'h10; B = 8'h10; Op = 4'd7;
    @(posedge Clk); #1;
    chk("b2b_cmp_valid", OutValid, 1'b1);
    chk("b2b_cmp_res", Result, 8'hFF);
    chk("b2b_cmp_flags", Flags, 5'b00100);
    InValid = 1'b0;
    @(posedge Clk); #1;
    chk("b2b_idle_valid", OutValid, 1'b0);
    OutReady = 1'b0;

    // SHR with back-pressure; a competing request must be ignored
    @(negedge Clk);
    A = 8'h81; B = 8'h03; Op = 4'd2; InValid = 1'b1; OutReady = 1'b0;
    @(posedge Clk); #1;
    A = 8'h01; B = 8'h01; Op = 4'd0;
    lat = 1;
    while (OutValid !== 1'b1 && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    chk("hold_lat", lat, 4);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_res", i), Result, 8'h10);
      chk($sformatf("hold%0d_flags", i), Flags, 5'b00000);
      chk($sformatf("hold%0d_valid", i), OutValid, 1'b1);
      chk($sformatf("hold%0d_inready", i), InReady, 1'b0);
      @(posedge Clk); #1;
    end
    InValid = 1'b0; OutReady = 1'b1;
    @(posedge Clk); #1;
    chk("hold_release_valid", OutValid, 1'b0);
    OutReady = 1'b0;

    // Reset during SHL: Result currently holds 0x10 from the previous op
    @(negedge Clk);
    A = 8'h01; B = 8'h07; Op = 4'd1; InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    chk("abort_valid", OutValid, 1'b0);
    chk("abort_result", Result, 8'h00);
    chk("abort_flags", Flags, 5'b00000);
    chk("abort_inready", InReady, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("abort_rel_inready", InReady, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      chk($sformatf("abort_stale%0d", i), OutValid, 1'b0);
    end
    chk("abort_final_result", Result, 8'h00);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, flg, lat);
      chk($sformatf("vec%0d_op%0d_res", i, vecs[i].op), res, vecs[i].res);
      chk($sformatf("vec%0d_op%0d_flags", i, vecs[i].op), flg, vecs[i].flg);
      chk($sformatf("vec%0d_op%0d_lat", i, vecs[i].op), lat, vecs[i].lat);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
